fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter depth, 8, FIFO depth; sets the stall-watchdog default only.
REQ-002 Parameter WIDTH, 8, data word width.
REQ-003 Parameter NREQ, 4, number of write requesters; a power of 2 and at least 2.
REQ-004 Parameter BURST_LEN, 4, maximum words per grant.
REQ-005 Parameter STALL_MAX, 2*depth, consecutive full cycles before a burst is aborted.
REQ-006 wclk  in  1  single clock; one clock; reset is synchronous and active-high.
REQ-007 reset  in  1  synchronous, active-high reset, sampled on rising wclk.
REQ-008 req  in  NREQ  per-requester "has data" level.
REQ-009 wdata_in  in  NREQ*WIDTH  flattened requester data; slice i belongs to requester i.
REQ-010 full  in  1  FIFO full flag, write-domain synchronous.
REQ-011 w_en  out  1  FIFO write enable.
REQ-012 w_data  out  WIDTH  FIFO write data; equals the owner's slice.
REQ-013 gnt  out  NREQ  one-hot grant owner, registered.
REQ-014 ack  out  NREQ  word-accepted strobe; ack = gnt when w_en=1, else 0.
REQ-015 busy  out  1  high in state BURST.
REQ-016 stall_err  out  1  one-cycle pulse when a burst is aborted by the watchdog.

Function
REQ-017 States SHALL be IDLE and BURST, with registers owner, rr_ptr, cnt (0..BURST_LEN-1) and stall_cnt.
REQ-018 IDLE: if req!=0, the first set req bit searched circularly from rr_ptr SHALL be latched as owner; next state BURST, cnt=0, stall_cnt=0, gnt=onehot(owner); else remain IDLE.
REQ-019 In BURST, w_en SHALL be req[owner] AND NOT full, combinationally from registered state; w_en=0 in IDLE.
REQ-020 A word SHALL be written on each rising wclk with w_en=1; cnt increments on each write.
REQ-021 On a write with cnt==BURST_LEN-1, the next state SHALL be IDLE with rr_ptr=owner+1 mod NREQ and gnt=0.
REQ-022 In BURST with req[owner]=0, the next state SHALL be IDLE with rr_ptr=owner+1 and no write that cycle.
REQ-023 In BURST with full=1 and req[owner]=1: stall; cnt held, stall_cnt increments, w_en=0.
REQ-024 Any write SHALL clear stall_cnt.
REQ-025 When stall_cnt reaches STALL_MAX-1 while still stalled, the next state SHALL be IDLE, rr_ptr=owner+1, with a one-cycle stall_err pulse.
REQ-026 IDLE SHALL last at least one cycle between bursts, a fixed one-cycle bubble.
REQ-027 Grant latency SHALL be 1 cycle from req sampled in IDLE to gnt high.
REQ-028 Requester changes of req bits other than owner SHALL not affect an active burst.
REQ-029 w_data SHALL be a pure mux of wdata_in by owner.

Reset
REQ-030 On reset=1 at a wclk edge: state=IDLE, owner=0, rr_ptr=0, cnt=0, stall_cnt=0, gnt=0, busy=0, stall_err=0; w_en=0 and ack=0 follow.
REQ-031 Reset mid-burst SHALL abort without a write on that edge; in-flight burst state is discarded.

Structure
REQ-032 Package fifo_pkg SHALL hold the parameter defaults for depth, WIDTH, NREQ and BURST_LEN, plus the IDLE/BURST state encoding.
REQ-033 Sub-module rr_pick SHALL be a combinational circular priority picker (req, rr_ptr -> index, valid) instantiated once.

Verification
REQ-034 Reset for 2 cycles, then req=4'b0001 held with full=0 -> gnt=0001 one cycle later, 4 consecutive w_en pulses, then gnt=0 for 1 cycle, then gnt=0001 again.
REQ-035 req=4'b1111, full=0 -> bursts granted in order 0,1,2,3,0, each with 4 writes and ack matching gnt.
REQ-036 Owner 2 bursting, full=1 on the 2nd word for 3 cycles -> w_en=0 for those 3 cycles, cnt held, burst completes with 4 total writes.
REQ-037 full held 16 cycles mid-burst (depth=8) -> stall_err pulses once, gnt=0, rr_ptr advances to the next requester.
REQ-038 Owner drops req after 2 writes -> return to IDLE with 2 writes, next grant goes to owner+1.
REQ-039 reset=1 asserted mid-burst -> next cycle all outputs 0; first grant after reset comes from requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and state encoding for the FIFO write-side arbiter.
package fifo_pkg;

    localparam int DEPTH_DEF     = 8;
    localparam int WIDTH_DEF     = 8;
    localparam int NREQ_DEF      = 4;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr_i.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    logic [IDXW-1:0] cand_s;
    logic            found_s;

    // Walk the requesters once starting at the pointer; index arithmetic wraps for power-of-2 NREQ
    always_comb begin
        cand_s  = ptr_i;
        found_s = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = ptr_i + IDXW'(i);
            if (!found_s && req_i[cand_s]) begin
                idx_o   = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        valid_o = found_s;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that multiplexes NREQ requesters onto one FIFO write port,
// with a full-stall watchdog that aborts a burst stuck behind a full FIFO.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int depth     = DEPTH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int NREQ      = NREQ_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int STALL_MAX = 2 * depth
) (
    input  logic                  wclk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata_in,
    input  logic                  full,
    output logic                  w_en,
    output logic [WIDTH-1:0]      w_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic                  stall_err
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int STLW = $clog2(STALL_MAX + 1);
    localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(BURST_LEN - 1);
    localparam logic [STLW-1:0] STALL_LAST = STLW'(STALL_MAX - 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [STLW-1:0] stall_cnt_q, stall_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            stall_err_q, stall_err_d;

    logic [IDXW-1:0] pick_idx_s;
    logic            pick_vld_s;
    logic            own_req_s;
    logic            wr_s;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx_s),
        .valid_o (pick_vld_s)
    );

    assign own_req_s = req[owner_q];

    // State register with synchronous reset; reset discards any in-flight burst
    always_ff @(posedge wclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            gnt_q       <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            gnt_q       <= gnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Next-state logic; every burst exit hands priority to owner+1 and drops the grant
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        gnt_d       = gnt_q;
        stall_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_d     = ST_BURST;
                    owner_d     = pick_idx_s;
                    cnt_d       = '0;
                    stall_cnt_d = '0;
                    gnt_d       = NREQ'(1) << pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (!own_req_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_q + IDXW'(1);
                    gnt_d    = '0;
                end else if (full) begin
                    if (stall_cnt_q == STALL_LAST) begin
                        state_d     = ST_IDLE;
                        rr_ptr_d    = owner_q + IDXW'(1);
                        gnt_d       = '0;
                        stall_err_d = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + STLW'(1);
                    end
                end else begin
                    stall_cnt_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_q + IDXW'(1);
                        gnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output logic; the write strobe is masked while reset is high so an aborted burst never writes
    always_comb begin
        wr_s   = (state_q == ST_BURST) && own_req_s && !full && !reset;
        w_data = wdata_in[owner_q*WIDTH +: WIDTH];
        if (wr_s) begin
            ack = gnt_q;
        end else begin
            ack = '0;
        end
    end

    assign w_en      = wr_s;
    assign gnt       = gnt_q;
    assign busy      = (state_q == ST_BURST);
    assign stall_err = stall_err_q;

endmodule
